// File: rtl/ram_arb_pkg.sv
// Shared types and size-code constants for the unified-RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {IFU, LSU} owner_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Size code must be one of the three legal masks and naturally aligned.
    function automatic logic is_legal(input logic [3:0] mask, input logic [1:0] lsb);
        logic ok;
        case (mask)
            MASK_W:  ok = (lsb == 2'b00);
            MASK_H:  ok = !lsb[0];
            MASK_B:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker between IFU and LSU; a tie goes to whoever
// was not granted last. Also computes the next value of the last register.
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       req_ifu,
    input  logic       req_lsu,
    input  owner_t     last,
    input  logic       hs,
    output logic [1:0] grant,
    output owner_t     last_nxt
);

    always_comb begin
        grant    = 2'b00;
        last_nxt = last;
        if (req_ifu && (!req_lsu || last == LSU)) begin
            grant[0] = 1'b1;
        end else if (req_lsu) begin
            grant[1] = 1'b1;
        end
        if (hs) begin
            last_nxt = grant[1] ? LSU : IFU;
        end
    end

endmodule

// File: rtl/cfg.sv
// Build-wide configuration macros shared by the RAM subsystem.
// Guarded so the file can be both compiled and included.
`ifndef RAM_CFG_SV
`define RAM_CFG_SV
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`endif

// File: rtl/ram_arb.sv
// Arbiter/sequencer between IFU and LSU for the shared unified RAM:
// one request at a time, one dedicated access cycle, registered response.
`include "cfg.sv"

module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
    output logic                    o_ifu_rsp_valid,
    input  logic                    i_ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_ifu_rsp_data,
    output logic                    o_ifu_rsp_err,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic                    i_lsu_req_wr,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_lsu_req_data,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_req_mask,
    output logic                    o_lsu_rsp_valid,
    input  logic                    i_lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_lsu_rsp_data,
    output logic                    o_lsu_rsp_err,
    output logic                    o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
    output logic                    o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask
);

    localparam int MW = DATA_WIDTH / 8;

    state_t                state, state_nxt;
    owner_t                last, last_nxt, owner;
    logic [1:0]            grant;
    logic                  req_hs, rsp_hs;
    logic                  acc_wr, acc_legal;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data, rd_capture;
    logic [MW-1:0]         acc_mask;

    // Requests are only visible to the picker while idle and out of reset.
    arb_rr2 u_arb (
        .req_ifu  (i_ifu_req_valid && state == IDLE && !i_sys_rst),
        .req_lsu  (i_lsu_req_valid && state == IDLE && !i_sys_rst),
        .last     (last),
        .hs       (req_hs),
        .grant    (grant),
        .last_nxt (last_nxt)
    );

    assign req_hs     = |grant;
    assign rd_capture = (acc_legal && !acc_wr) ? i_ram_rd_data : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nxt       = state;
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        o_ram_rd_en     = 1'b0;
        o_ram_rd_addr   = '0;
        o_ram_wr_en     = 1'b0;
        o_ram_wr_addr   = '0;
        o_ram_wr_data   = '0;
        o_ram_wr_mask   = '0;
        rsp_hs          = (owner == IFU) ? (o_ifu_rsp_valid && i_ifu_rsp_ready)
                                         : (o_lsu_rsp_valid && i_lsu_rsp_ready);
        case (state)
            IDLE: begin
                o_ifu_req_ready = grant[0];
                o_lsu_req_ready = grant[1];
                if (req_hs) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
                // Stores also drive the read port so the RAM can merge unwritten bytes.
                if (acc_legal) begin
                    o_ram_rd_en   = 1'b1;
                    o_ram_rd_addr = acc_addr;
                    if (acc_wr) begin
                        o_ram_wr_en   = !i_sys_rst;
                        o_ram_wr_addr = acc_addr;
                        o_ram_wr_data = acc_data;
                        o_ram_wr_mask = acc_mask;
                    end
                end
            end
            RESP: begin
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state           <= IDLE;
            last            <= LSU;
            owner           <= IFU;
            acc_wr          <= 1'b0;
            acc_legal       <= 1'b0;
            acc_addr        <= '0;
            acc_data        <= '0;
            acc_mask        <= '0;
            o_ifu_rsp_valid <= 1'b0;
            o_ifu_rsp_data  <= '0;
            o_ifu_rsp_err   <= 1'b0;
            o_lsu_rsp_valid <= 1'b0;
            o_lsu_rsp_data  <= '0;
            o_lsu_rsp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep register updates independent of statement order.
            state <= state_nxt;
            last  <= last_nxt;
            if (req_hs) begin
                owner <= grant[1] ? LSU : IFU;
                if (grant[1]) begin
                    acc_wr    <= i_lsu_req_wr;
                    acc_addr  <= i_lsu_req_addr;
                    acc_data  <= i_lsu_req_data;
                    acc_mask  <= i_lsu_req_mask;
                    acc_legal <= is_legal(i_lsu_req_mask, i_lsu_req_addr[1:0]);
                end else begin
                    acc_wr    <= 1'b0;
                    acc_addr  <= i_ifu_req_addr;
                    acc_data  <= '0;
                    acc_mask  <= MW'(MASK_W);
                    acc_legal <= is_legal(MASK_W, i_ifu_req_addr[1:0]);
                end
            end
            if (state == ACCESS) begin
                if (owner == IFU) begin
                    o_ifu_rsp_valid <= 1'b1;
                    o_ifu_rsp_data  <= rd_capture;
                    o_ifu_rsp_err   <= !acc_legal;
                end else begin
                    o_lsu_rsp_valid <= 1'b1;
                    o_lsu_rsp_data  <= rd_capture;
                    o_lsu_rsp_err   <= !acc_legal;
                end
            end
            if (state == RESP && rsp_hs) begin
                o_ifu_rsp_valid <= 1'b0;
                o_ifu_rsp_data  <= '0;
                o_ifu_rsp_err   <= 1'b0;
                o_lsu_rsp_valid <= 1'b0;
                o_lsu_rsp_data  <= '0;
                o_lsu_rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Directed self-checking bench for ram_arb with a small byte-merging RAM model.
module tb_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_req_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wr, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_req_addr, lsu_req_data, lsu_rsp_data;
    logic [3:0]  lsu_req_mask;
    logic        ram_rd_en, ram_wr_en;
    logic [31:0] ram_rd_addr, ram_rd_data, ram_wr_addr, ram_wr_data;
    logic [3:0]  ram_wr_mask;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_count = 0;
    logic        mem_init;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    ram_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_sys_clk       (clk),
        .i_sys_rst       (rst),
        .i_ifu_req_valid (ifu_req_valid),
        .o_ifu_req_ready (ifu_req_ready),
        .i_ifu_req_addr  (ifu_req_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .i_ifu_rsp_ready (ifu_rsp_ready),
        .o_ifu_rsp_data  (ifu_rsp_data),
        .o_ifu_rsp_err   (ifu_rsp_err),
        .i_lsu_req_valid (lsu_req_valid),
        .o_lsu_req_ready (lsu_req_ready),
        .i_lsu_req_wr    (lsu_req_wr),
        .i_lsu_req_addr  (lsu_req_addr),
        .i_lsu_req_data  (lsu_req_data),
        .i_lsu_req_mask  (lsu_req_mask),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .i_lsu_rsp_ready (lsu_rsp_ready),
        .o_lsu_rsp_data  (lsu_rsp_data),
        .o_lsu_rsp_err   (lsu_rsp_err),
        .o_ram_rd_en     (ram_rd_en),
        .o_ram_rd_addr   (ram_rd_addr),
        .i_ram_rd_data   (ram_rd_data),
        .o_ram_wr_en     (ram_wr_en),
        .o_ram_wr_addr   (ram_wr_addr),
        .o_ram_wr_data   (ram_wr_data),
        .o_ram_wr_mask   (ram_wr_mask)
    );

    // RAM model: combinational read, size-coded right-justified write merged at the byte offset.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [3:0] m, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) begin
            if (m[b] && (b + int'(off)) < 4) r[8*(b+int'(off)) +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    assign ram_rd_data = mem[ram_rd_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hCAFE_F00D;
            mem[1] <= 32'h5566_7788;
            mem[2] <= 32'h1122_3344;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (ram_wr_en) begin
            wr_count <= wr_count + 1;
            mem[ram_wr_addr[7:2]] <= merge(mem[ram_wr_addr[7:2]], ram_wr_data, ram_wr_mask, ram_wr_addr[1:0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " flags"}, 32'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                    ifu_rsp_err, lsu_rsp_err, ram_rd_en, ram_wr_en}), 0);
        check({tag, " ifu_data"}, ifu_rsp_data, 0);
        check({tag, " lsu_data"}, lsu_rsp_data, 0);
        check({tag, " rd_addr"}, ram_rd_addr, 0);
        check({tag, " wr_addr"}, ram_wr_addr, 0);
        check({tag, " wr_data"}, ram_wr_data, 0);
        check({tag, " wr_mask"}, 32'(ram_wr_mask), 0);
    endtask

    // Starts right after a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic lsu_txn(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [31:0] exp_data, input logic exp_err,
                           input int stall, input logic ifu_wait);
        lsu_req_valid = 1'b1;
        lsu_req_wr    = wr;
        lsu_req_addr  = addr;
        lsu_req_data  = data;
        lsu_req_mask  = mask;
        lsu_rsp_ready = 1'b0;
        #1 check({tag, " req_ready"}, 32'(lsu_req_ready), 1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        ifu_req_valid = ifu_wait;
        ifu_req_addr  = 32'h10;
        check({tag, " acc rd_en"}, 32'(ram_rd_en), 32'(!exp_err));
        check({tag, " acc wr_en"}, 32'(ram_wr_en), 32'(wr && !exp_err));
        check({tag, " acc rd_addr"}, ram_rd_addr, exp_err ? 32'h0 : addr);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check({tag, " rsp_valid"}, 32'(lsu_rsp_valid), 1);
            check({tag, " rsp_data"}, lsu_rsp_data, exp_data);
            check({tag, " rsp_err"}, 32'(lsu_rsp_err), 32'(exp_err));
            check({tag, " ifu_ready in resp"}, 32'(ifu_req_ready), 0);
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        lsu_rsp_ready = 1'b0;
        check({tag, " rsp_valid after hs"}, 32'(lsu_rsp_valid), 0);
        check({tag, " ifu_ready after hs"}, 32'(ifu_req_ready), 32'(ifu_wait));
        ifu_req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h0; ifu_rsp_ready = 1'b0;
        lsu_req_valid = 1'b0; lsu_req_wr = 1'b0; lsu_req_addr = 32'h0;
        lsu_req_data = 32'h0; lsu_req_mask = 4'h0; lsu_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        check_all_zero("reset");

        // Collision right after reset: IFU wins the first tie.
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b1; lsu_req_wr = 1'b0; lsu_req_addr = 32'h4; lsu_req_mask = 4'hF;
        ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        #1 check("tie1 ifu_ready", 32'(ifu_req_ready), 1);
        check("tie1 lsu_ready", 32'(lsu_req_ready), 0);
        @(negedge clk);
        check("ifu0 acc rd_en", 32'(ram_rd_en), 1);
        check("ifu0 acc rd_addr", ram_rd_addr, 32'h0);
        check("ifu0 acc ifu_ready", 32'(ifu_req_ready), 0);
        ifu_req_addr = 32'h10;
        @(negedge clk);
        check("ifu0 rsp_valid", 32'(ifu_rsp_valid), 1);
        check("ifu0 rsp_data", ifu_rsp_data, 32'hCAFE_F00D);
        check("ifu0 rsp_err", 32'(ifu_rsp_err), 0);
        check("ifu0 lsu_ready in resp", 32'(lsu_req_ready), 0);
        @(negedge clk);
        check("tie2 lsu_ready", 32'(lsu_req_ready), 1);
        check("tie2 ifu_ready", 32'(ifu_req_ready), 0);
        @(negedge clk);
        check("lsu0 acc rd_addr", ram_rd_addr, 32'h4);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("lsu0 rsp_valid", 32'(lsu_rsp_valid), 1);
        check("lsu0 rsp_data", lsu_rsp_data, 32'h5566_7788);
        check("lsu0 rsp_err", 32'(lsu_rsp_err), 0);
        lsu_req_valid = 1'b1;
        @(negedge clk);
        check("tie3 ifu_ready", 32'(ifu_req_ready), 1);
        check("tie3 lsu_ready", 32'(lsu_req_ready), 0);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        check("ifu1 acc rd_addr", ram_rd_addr, 32'h10);
        @(negedge clk);
        check("ifu1 rsp_valid", 32'(ifu_rsp_valid), 1);
        check("ifu1 rsp_data", ifu_rsp_data, 32'hDEAD_BEEF);
        check("ifu1 rsp_err", 32'(ifu_rsp_err), 0);
        @(negedge clk);
        check("tie3 lsu_ready next", 32'(lsu_req_ready), 1);
        lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b0;

        // Stores, loads, illegal requests and a stalled response.
        lsu_txn("stb", 1'b1, 32'h9, 32'hAA, 4'b0001, 32'h0, 1'b0, 0, 1'b0);
        check("stb mem", mem[2], 32'h1122_AA44);
        check("stb wr_count", 32'(wr_count), 1);
        lsu_txn("ldw stall", 1'b0, 32'h8, 32'h0, 4'b1111, 32'h1122_AA44, 1'b0, 5, 1'b1);
        lsu_txn("sth mis", 1'b1, 32'h3, 32'hBEEF, 4'b0011, 32'h0, 1'b1, 0, 1'b0);
        lsu_txn("bad mask", 1'b1, 32'h0, 32'h1234_5678, 4'b0101, 32'h0, 1'b1, 0, 1'b0);
        check("illegal wr_count", 32'(wr_count), 1);
        check("illegal mem0", mem[0], 32'hCAFE_F00D);
        lsu_txn("sth", 1'b1, 32'h6, 32'h9999, 4'b0011, 32'h0, 1'b0, 0, 1'b0);
        check("sth mem", mem[1], 32'h9999_7788);
        check("sth wr_count", 32'(wr_count), 2);

        // Reset during the access cycle of a word store.
        lsu_req_valid = 1'b1; lsu_req_wr = 1'b1; lsu_req_addr = 32'h0;
        lsu_req_data = 32'h1234_5678; lsu_req_mask = 4'hF;
        #1 check("rst store req_ready", 32'(lsu_req_ready), 1);
        @(negedge clk);
        rst = 1'b1; lsu_req_valid = 1'b0;
        #1 check("rst store wr_en gated", 32'(ram_wr_en), 0);
        @(negedge clk);
        check_all_zero("midrst");
        check("midrst mem0", mem[0], 32'hCAFE_F00D);
        check("midrst wr_count", 32'(wr_count), 2);
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b1; lsu_req_wr = 1'b0; lsu_req_addr = 32'h8;
        #1 check("post rst ifu_ready", 32'(ifu_req_ready), 1);
        check("post rst lsu_ready", 32'(lsu_req_ready), 0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arb.md
# ram_arb

Arbiter and sequencer for the shared unified `ram`. It sits between the instruction-fetch unit (read-only requester) and the load/store unit (read/write requester), and drives the RAM's single read port and single write port. It grants one request at a time with 2-way round-robin, checks alignment and size, and performs the access in a dedicated cycle. For sub-word stores, it presents the store address on the read port so the RAM's combinational merge writes the correct bytes. The result is returned through a registered valid/ready response.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (32): byte address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): data width. Only 32 is supported.

Ports:
- `i_sys_clk`, in, 1: the single clock.
- `i_sys_rst`, in, 1: reset, synchronous, active-high.
- `i_ifu_req_valid` / `o_ifu_req_ready`, in / out, 1: IFU request handshake.
- `i_ifu_req_addr`, in, `ADDR_WIDTH`: fetch address; must be word aligned.
- `o_ifu_rsp_valid` / `i_ifu_rsp_ready`, out / in, 1: IFU response handshake.
- `o_ifu_rsp_data`, out, `DATA_WIDTH`: fetched word.
- `o_ifu_rsp_err`, out, 1: misaligned fetch.
- `i_lsu_req_valid` / `o_lsu_req_ready`, in / out, 1: LSU request handshake.
- `i_lsu_req_wr`, in, 1: 1 = store, 0 = load.
- `i_lsu_req_addr`, in, `ADDR_WIDTH`: byte address.
- `i_lsu_req_data`, in, `DATA_WIDTH`: store data, right-justified.
- `i_lsu_req_mask`, in, `DATA_WIDTH/8`: size code: 0001 = byte, 0011 = half, 1111 = word.
- `o_lsu_rsp_valid` / `i_lsu_rsp_ready`, out / in, 1: LSU response handshake.
- `o_lsu_rsp_data`, out, `DATA_WIDTH`: loaded word; 0 for stores.
- `o_lsu_rsp_err`, out, 1: misaligned access or illegal mask.
- `o_ram_rd_en`, `o_ram_rd_addr`, `i_ram_rd_data`, `o_ram_wr_en`, `o_ram_wr_addr`, `o_ram_wr_data`, `o_ram_wr_mask`: the RAM port set, with matching widths.

## Operation
- FSM states:
  - IDLE: `o_ifu_req_ready` and `o_lsu_req_ready` are asserted only for the granted requester.
  - ACCESS: one cycle; the RAM access is performed.
  - RESP: `rsp_valid` is held on the owner's port until that port's `rsp_ready`.
- Transitions: IDLE -> ACCESS on a request handshake; ACCESS -> RESP always; RESP -> IDLE on the `rsp` handshake.
- Arbitration:
  - A single requester wins immediately.
  - When both request, the winner is the one not granted last. The `last` register resets to LSU, so IFU wins the first tie.
  - Grant is combinational in IDLE. The address, data, mask, wr flag and owner are latched at the handshake.
- Legality is checked at latch time:
  - word: `addr[1:0]`==0;
  - half: `addr[0]`==0;
  - byte: any address;
  - any other mask is illegal.
  - An illegal request skips the RAM access: ACCESS drives no enables, RESP returns `err`=1 and `data`=0.
- ACCESS, IFU or load:
  - `o_ram_rd_en`=1, `o_ram_rd_addr`=latched address.
  - `i_ram_rd_data` is captured into the response data register.
- ACCESS, store:
  - `o_ram_wr_en`=1; `wr_addr`/`wr_data`/`wr_mask` are driven from the latched values.
  - `o_ram_rd_en`=1 with `o_ram_rd_addr`=latched address, so the RAM merges the unwritten bytes.
  - Response data is 0.
- Outside ACCESS, all RAM enables are 0 and the RAM address/data/mask outputs are 0.
- Store atomicity: `o_ram_wr_en` is gated by `!i_sys_rst`. No write commits in a cycle where reset is asserted.

## Timing
- Reset (synchronous, sampled at posedge): state=IDLE, `last`=LSU. Every output is 0: both `req_ready`, both `rsp_valid`/`data`/`err`, and all RAM outputs.
- Latency: request handshake at cycle T, ACCESS at T+1, `rsp_valid` from T+2. Minimum 3 cycles per transaction; the next request is accepted no earlier than the cycle after the response handshake.
- `rsp_valid`/`data`/`err` are registered and stay stable until the handshake.
- `req_ready` is 0 in ACCESS and RESP; a requester holds its request.
- Simultaneous valid from both requesters in IDLE: exactly one `req_ready` is high.
- Reset mid-transaction: the FSM returns to IDLE, the pending response is dropped and `last` is reset.
- Address bits above the RAM depth pass through unchecked; the RAM wraps them.

## Structure
- Package `ram_arb_pkg` holds:
  - the `state_t` enum (IDLE, ACCESS, RESP);
  - the `owner_t` enum (IFU, LSU);
  - the mask constants `MASK_B`=4'b0001, `MASK_H`=4'b0011, `MASK_W`=4'b1111.
- Sub-module `arb_rr2`: the 2-way round-robin picker. Inputs: two requests, `last`, and the handshake pulse that updates `last`. Output: a one-hot grant.
- All macros come from `cfg.sv`.

## Test plan
- IFU only, addr 0x10, RAM word[4]=0xDEADBEEF -> `ifu_req_ready` high in IDLE, `o_ifu_rsp_valid` 2 cycles after the handshake, data 0xDEADBEEF, err 0.
- Both valid in the cycle after reset, IFU addr 0x0 and LSU load addr 0x4 -> IFU granted first, LSU granted in the first IDLE after the IFU response. Repeating the collision alternates LSU, IFU.
- LSU store byte 0xAA at 0x9 over word 0x11223344 -> during ACCESS `rd_en`=1, `rd_addr`=0x9, `wr_en`=1; the word then reads back 0x1122AA44.
- LSU store half at 0x3 (mask 0011), and a separate store with mask 0101 -> `err`=1, `data`=0, `o_ram_wr_en` never asserted, memory unchanged.
- `rsp_ready` held low 5 cycles -> `rsp_valid` and `data` stable for all 5 cycles; no new `req_ready` until the handshake.
- Reset asserted during the ACCESS cycle of a word store -> no write to RAM, all outputs 0 the next cycle, state IDLE.
